// File: rtl/target_pkg.sv
// target_pkg: shared shot-state encoding and default sizing for the target counter array.
package target_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, RUNNING, DONE} state_t;
    localparam int NCH_DEF = 8;
    localparam int CW_DEF  = 16;
    localparam int TMO_DEF = 65535;
endpackage

// File: rtl/target_channel.sv
// target_channel: one microphone channel -- trigger capture, run/hit/ovf flags and saturating counter.
module target_channel
    import target_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          ares,
    input  logic          clr_i,
    input  logic          start_en_i,
    input  logic          stop_i,
    input  logic          quiet_i,
    input  logic          start_n_i,
    output logic          run_o,
    output logic          hit_o,
    output logic          ovf_o,
    output logic [CW-1:0] count_o
);
    logic          run_q, hit_q, ovf_q;
    logic [CW-1:0] cnt_q;
    logic          trig, inc, sat;

    // a channel triggers once per shot; later starts on it are ignored
    assign trig = start_en_i & ~start_n_i & ~hit_q;
    assign inc  = run_q & quiet_i;
    assign sat  = &cnt_q;

    always_ff @(posedge clk) begin
        if (ares || clr_i) begin
            run_q <= 1'b0;
            hit_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (inc && !sat) cnt_q <= CW'(cnt_q + 1'b1);
            if (inc && sat) ovf_q <= 1'b1;
            hit_q <= hit_q | trig;
            run_q <= stop_i ? 1'b0 : (run_q | trig);
        end
    end

    assign run_o   = run_q;
    assign hit_o   = hit_q;
    assign ovf_o   = ovf_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/target_counter_array.sv
// target_counter_array: NCH trigger-to-stop counters framed by an arm/run/done FSM
// with no-stop timeout, first-channel capture and a registered count read-out.
module target_counter_array
    import target_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic                   clk,
    input  logic                   ares,
    input  logic                   arm,
    input  logic                   clear,
    input  logic                   quiet,
    input  logic [NCH-1:0]         start_n,
    input  logic                   stop_n,
    input  logic [$clog2(NCH)-1:0] sel,
    output logic [NCH-1:0]         run,
    output logic [NCH-1:0]         hit,
    output logic [NCH-1:0]         ovf,
    output logic [CW-1:0]          count_sel,
    output logic [$clog2(NCH)-1:0] first_ch,
    output logic                   done,
    output logic                   timeout
);
    localparam int SW = $clog2(NCH);
    localparam int TW = $clog2(TMO + 1);

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [SW-1:0] first_q, first_d;
    logic          done_q, tmo_q;
    logic [CW-1:0] count_sel_q;
    logic [CW-1:0] cnt [2**SW];
    logic          any_start, tmo_hit, clr, start_en, stop;

    assign any_start = ~&start_n;
    assign tmo_hit   = timer_q == TW'(TMO - 1);
    // counters are zeroed while idle, on abort, and when re-arming from a finished shot
    assign clr       = clear | (state_q == IDLE) | ((state_q == DONE) & arm);
    assign start_en  = ~clear & ((state_q == ARMED) | (state_q == RUNNING));
    assign stop      = ~clear & (state_q == RUNNING) & (~stop_n | tmo_hit);

    always_comb begin
        first_d = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (!start_n[i]) first_d = SW'(i);
    end

    always_ff @(posedge clk) begin
        if (ares || clear) begin
            state_q <= IDLE;
            timer_q <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (arm) state_q <= ARMED;
                ARMED: if (any_start) begin
                    state_q <= RUNNING;
                    first_q <= first_d;
                    timer_q <= '0;
                end
                RUNNING: begin
                    timer_q <= TW'(timer_q + 1'b1);
                    if (!stop_n || tmo_hit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        tmo_q   <= stop_n;
                    end
                end
                DONE: if (arm) begin
                    state_q <= ARMED;
                    timer_q <= '0;
                    first_q <= '0;
                    done_q  <= 1'b0;
                    tmo_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk)
        count_sel_q <= (ares || clr) ? '0 : cnt[sel];

    for (genvar i = 0; i < 2**SW; i++) begin : g_ch
        if (i < NCH) begin : g_on
            target_channel #(.CW(CW)) u_ch (
                .clk       (clk),
                .ares      (ares),
                .clr_i     (clr),
                .start_en_i(start_en),
                .stop_i    (stop),
                .quiet_i   (quiet),
                .start_n_i (start_n[i]),
                .run_o     (run[i]),
                .hit_o     (hit[i]),
                .ovf_o     (ovf[i]),
                .count_o   (cnt[i])
            );
        end else begin : g_off
            assign cnt[i] = '0;
        end
    end

    assign count_sel = count_sel_q;
    assign first_ch  = first_q;
    assign done      = done_q;
    assign timeout   = tmo_q;
endmodule

// File: tb/tb_target_counter_array.sv
// tb_target_counter_array: directed shots plus randomized traffic checked against a shot-level model.
module tb_target_counter_array;
    localparam int NCH = 8;
    localparam int CW  = 6;
    localparam int TMO = 50;
    localparam int SW  = 3;
    localparam int CAP = (1 << CW) - 1;

    logic clk = 1'b0;
    logic ares, arm, clear, quiet, stop_n;
    logic [NCH-1:0] start_n;
    logic [SW-1:0]  sel;
    logic [NCH-1:0] run, hit, ovf;
    logic [CW-1:0]  count_sel;
    logic [SW-1:0]  first_ch;
    logic done, timeout;

    logic s_arm, s_clear, s_stop_n, s_sel;
    logic [1:0] s_start_n, s_run, s_hit, s_ovf;
    logic [3:0] s_count_sel;
    logic s_first_ch, s_done, s_timeout;

    target_counter_array #(.NCH(NCH), .CW(CW), .TMO(TMO)) dut (
        .clk(clk), .ares(ares), .arm(arm), .clear(clear), .quiet(quiet),
        .start_n(start_n), .stop_n(stop_n), .sel(sel), .run(run), .hit(hit),
        .ovf(ovf), .count_sel(count_sel), .first_ch(first_ch), .done(done),
        .timeout(timeout)
    );

    target_counter_array #(.NCH(2), .CW(4), .TMO(50)) dut_s (
        .clk(clk), .ares(ares), .arm(s_arm), .clear(s_clear), .quiet(1'b1),
        .start_n(s_start_n), .stop_n(s_stop_n), .sel(s_sel), .run(s_run), .hit(s_hit),
        .ovf(s_ovf), .count_sel(s_count_sel), .first_ch(s_first_ch), .done(s_done),
        .timeout(s_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Shot-level model: n[i] is the number of enabled count cycles a channel has seen;
    // the visible count is that number clipped at CAP, and ovf means it went past CAP.
    int ms, el, mfirst, mcs;
    int n [NCH];
    logic [NCH-1:0] mrun, mhit;
    bit mdone, mtmo;

    function automatic int clip(int v);
        return v > CAP ? CAP : v;
    endfunction

    function automatic void mzero();
        ms = 0; el = 0; mfirst = 0; mdone = 0; mtmo = 0; mrun = '0; mhit = '0;
        for (int i = 0; i < NCH; i++) n[i] = 0;
    endfunction

    function automatic void model_step();
        bit ends;
        int cs;
        cs = (ares || clear || (ms == 3 && arm)) ? 0 : clip(n[sel]);
        if (ares || clear) mzero();
        else if (ms == 0) begin
            if (arm) ms = 1;
        end else if (ms == 1) begin
            if (start_n != '1) begin
                mfirst = -1;
                for (int i = 0; i < NCH; i++)
                    if (!start_n[i]) begin
                        mrun[i] = 1'b1; mhit[i] = 1'b1;
                        if (mfirst < 0) mfirst = i;
                    end
                ms = 2; el = 0;
            end
        end else if (ms == 2) begin
            ends = !stop_n || (el + 1 == TMO);
            for (int i = 0; i < NCH; i++) if (mrun[i] && quiet) n[i]++;
            for (int i = 0; i < NCH; i++)
                if (!start_n[i] && !mhit[i]) begin mhit[i] = 1'b1; mrun[i] = !ends; end
            if (ends) begin mrun = '0; ms = 3; mdone = 1; mtmo = stop_n; end
            el++;
        end else if (arm) begin
            mzero(); ms = 1;
        end
        mcs = cs;
    endfunction

    initial mzero();
    always @(posedge clk) model_step();

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        logic [NCH-1:0] eovf;
        for (int i = 0; i < NCH; i++) eovf[i] = n[i] > CAP;
        cmp("run", run, mrun);
        cmp("hit", hit, mhit);
        cmp("ovf", ovf, eovf);
        cmp("count_sel", count_sel, mcs);
        cmp("first_ch", first_ch, mfirst);
        cmp("done", done, mdone);
        cmp("timeout", timeout, mtmo);
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic idle_in();
        arm = 0; clear = 0; quiet = 1; stop_n = 1; start_n = '1;
    endtask

    task automatic do_clear();
        idle_in(); clear = 1; tick(); clear = 0;
    endtask

    task automatic basic(input int qlo, input int qhi);
        for (int e = 1; e <= 40; e++) begin
            idle_in();
            arm = (e == 1);
            start_n[3] = (e != 10);
            start_n[5] = (e != 14);
            stop_n = (e != 40);
            quiet = !(e >= qlo && e <= qhi);
            tick();
        end
        idle_in();
    endtask

    initial begin
        idle_in(); sel = 0; ares = 1;
        s_arm = 0; s_clear = 0; s_stop_n = 1; s_start_n = '1; s_sel = 0;
        tick();
        ares = 0; chk_en = 1;
        cmp("rst_outputs", {run, hit, ovf, count_sel, first_ch, done, timeout}, 64'd0);
        cmp("rst_s_outputs", {s_run, s_hit, s_ovf, s_count_sel, s_first_ch, s_done, s_timeout}, 64'd0);

        s_arm = 1; tick(); s_arm = 0;
        s_start_n = 2'b10; tick(); s_start_n = 2'b11;
        for (int c = 0; c < 10; c++) tick();
        cmp("sat_ovf_early", s_ovf, 2'b00);
        for (int c = 0; c < 9; c++) tick();
        s_stop_n = 0; tick(); s_stop_n = 1;
        tick();
        cmp("sat_count", s_count_sel, 4'd15);
        cmp("sat_ovf", s_ovf, 2'b01);
        cmp("sat_done", s_done, 1'b1);

        basic(0, -1);
        sel = 3; tick();
        cmp("basic_count3", count_sel, 30);
        sel = 5; tick();
        cmp("basic_count5", count_sel, 26);
        cmp("basic_hit", hit, 8'h28);
        cmp("basic_first", first_ch, 3);
        cmp("basic_done", done, 1'b1);
        cmp("basic_timeout", timeout, 1'b0);

        do_clear();
        basic(20, 24);
        sel = 3; tick();
        cmp("quiet_count3", count_sel, 25);

        do_clear();
        sel = 1;
        for (int e = 1; e <= 51; e++) begin
            idle_in(); arm = (e == 1); start_n[1] = (e != 2); tick();
        end
        cmp("tmo_not_yet", done, 1'b0);
        tick();
        cmp("tmo_done", done, 1'b1);
        cmp("tmo_flag", timeout, 1'b1);
        tick();
        cmp("tmo_count1", count_sel, 50);

        do_clear();
        arm = 1; tick(); arm = 0;
        start_n = 8'b1111_1010; tick(); start_n = '1;
        cmp("simul_first", first_ch, 0);
        for (int c = 0; c < 4; c++) tick();
        stop_n = 0; start_n[6] = 0; tick(); idle_in();
        sel = 6; tick();
        cmp("simul_hit", hit, 8'h45);
        cmp("simul_count6", count_sel, 0);
        cmp("simul_run", run, 8'h00);

        do_clear();
        arm = 1; tick(); arm = 0;
        start_n[4] = 0; tick(); start_n = '1;
        for (int c = 0; c < 5; c++) tick();
        sel = 4; clear = 1; tick(); clear = 0;
        cmp("clear_all_zero", {run, hit, ovf, count_sel, first_ch, done, timeout}, 64'd0);

        arm = 1; tick(); arm = 0;
        start_n[2] = 0; tick(); start_n = '1;
        for (int c = 0; c < 5; c++) tick();
        ares = 1; tick(); ares = 0;
        cmp("ares_all_zero", {run, hit, ovf, count_sel, first_ch, done, timeout}, 64'd0);
        arm = 1; tick(); arm = 0;
        start_n[2] = 0; tick(); start_n = '1;
        for (int c = 0; c < 6; c++) tick();
        stop_n = 0; tick(); stop_n = 1;
        sel = 2; tick();
        cmp("restart_count2", count_sel, 7);
        cmp("restart_first", first_ch, 2);
        cmp("restart_done", done, 1'b1);

        for (int c = 0; c < 4000; c++) begin
            ares = ($urandom_range(0, 599) == 0);
            clear = ($urandom_range(0, 99) == 0);
            arm = ($urandom_range(0, 7) == 0);
            quiet = ($urandom_range(0, 3) != 0);
            stop_n = (c < 2000) ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NCH; i++) start_n[i] = ($urandom_range(0, 19) != 0);
            sel = SW'($urandom_range(0, NCH - 1));
            tick();
        end
        ares = 0; idle_in();
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
